// File: rtl/prbs_checker.sv
// PRBS sequence checker with self-synchronising acquisition and flywheel tracking.
// In SEARCH, received bits fill a local shift register. Once that register is full,
// each received bit is compared against the bit predicted from the register.
// After enough consecutive matches the checker locks. While locked it predicts
// the stream on its own and counts the received bits that disagree.
module prbs_checker #(
    parameter int N           = 8,
    parameter int LOCK_THRESH = 16,
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 16
) (
`ifdef USE_POWER_PINS
    inout  wire              vccd1,
    inout  wire              vssd1,
`endif
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             s_in,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic             io_oeb
);

    localparam int FILL_W  = $clog2(N + 1);
    localparam int MATCH_W = $clog2(LOCK_THRESH + 1);
    localparam int MISS_W  = $clog2(LOSS_THRESH + 1);

    localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(N);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_THRESH - 1);
    localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_THRESH - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       r_q, r_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic               err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic               p;

    // Next-state: acquisition in SEARCH, flywheel prediction and error accounting in LOCKED.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        fill_d      = fill_q;
        match_d     = match_q;
        miss_d      = miss_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        p           = r_q[N-1] ^ r_q[N-3] ^ r_q[N-5];

        if (enable) begin
            case (state_q)
                SEARCH: begin
                    r_d = {r_q[N-2:0], s_in};
                    if (fill_q != FILL_FULL) fill_d = fill_q + 1'b1;
                    if (fill_q == FILL_FULL) begin
                        // An all-zero register predicts zeros forever, so it cannot count as a match.
                        if ((s_in == p) && (r_q != '0)) begin
                            match_d = match_q + 1'b1;
                            if (match_q == MATCH_LAST) begin
                                state_d = LOCKED;
                                miss_d  = '0;
                            end
                        end else begin
                            match_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    // Shift the predicted bit so that a corrupted received bit does not disturb tracking.
                    r_d = {r_q[N-2:0], p};
                    if (s_in != p) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != CNT_MAX) err_count_d = err_count_q + 1'b1;
                        if (miss_q == MISS_LAST) begin
                            state_d = SEARCH;
                            fill_d  = '0;
                            match_d = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + 1'b1;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        // Clear takes priority over an increment on the same edge.
        if (clear) err_count_d = '0;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SEARCH;
            r_q         <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign io_oeb    = 1'b0;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker. A reference generator with taps 7,5,3 is seeded 8'hFF.
// The bench drives two instances with the same inputs: one uses the default counter width
// and the other uses CNT_W=4.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        s_in = 1'b0;
    logic        clear = 1'b0;
    logic        locked, err_pulse, io_oeb;
    logic [15:0] err_count;
    logic        locked4, err_pulse4, io_oeb4;
    logic [3:0]  err_count4;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  g;

    prbs_checker dut (
        .clk(clk), .reset(reset), .enable(enable), .s_in(s_in), .clear(clear),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .io_oeb(io_oeb)
    );

    prbs_checker #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .enable(enable), .s_in(s_in), .clear(clear),
        .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4), .io_oeb(io_oeb4)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic send(input logic b, input logic en, input logic clr);
        @(negedge clk);
        s_in = b; enable = en; clear = clr;
        @(posedge clk);
        #1;
        enable = 1'b0; clear = 1'b0;
    endtask

    task automatic gen_next(output logic b);
        b = g[7] ^ g[5] ^ g[3];
        g = {g[6:0], b};
    endtask

    task automatic clean_bits(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            gen_next(b);
            send(b, 1'b1, 1'b0);
        end
    endtask

    task automatic flip_bit();
        logic b;
        gen_next(b);
        send(~b, 1'b1, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        g = 8'hFF;
    endtask

    task automatic relock();
        pulse_reset();
        clean_bits(24);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %b want 0", locked); end
        vectors++; if (err_pulse !== 1'b0) begin miscompares++; $display("FAIL reset_err_pulse: got %b want 0", err_pulse); end
        vectors++; if (err_count !== 16'd0) begin miscompares++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
        vectors++; if (err_count4 !== 4'd0) begin miscompares++; $display("FAIL reset_err_count4: got %0d want 0", err_count4); end
        vectors++; if (io_oeb !== 1'b0) begin miscompares++; $display("FAIL io_oeb: got %b want 0", io_oeb); end
        reset = 1'b1;
    endtask

    task automatic test_lock();
        logic b;
        int pulses = 0;
        int drops = 0;
        pulse_reset();
        clean_bits(23);
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL lock_early: got %b want 0 after 23 bits", locked); end
        clean_bits(1);
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL lock_24: got %b want 1 after 24 bits", locked); end
        for (int i = 0; i < 1000; i++) begin
            gen_next(b);
            send(b, 1'b1, 1'b0);
            if (err_pulse !== 1'b0) pulses++;
            if (locked !== 1'b1) drops++;
        end
        vectors++; if (pulses != 0) begin miscompares++; $display("FAIL clean_pulses: got %0d want 0", pulses); end
        vectors++; if (drops != 0) begin miscompares++; $display("FAIL clean_drops: got %0d want 0", drops); end
        vectors++; if (err_count !== 16'd0) begin miscompares++; $display("FAIL clean_err_count: got %0d want 0", err_count); end
    endtask

    task automatic test_single_err();
        relock();
        flip_bit();
        vectors++; if (err_pulse !== 1'b1) begin miscompares++; $display("FAIL single_pulse: got %b want 1", err_pulse); end
        vectors++; if (err_count !== 16'd1) begin miscompares++; $display("FAIL single_count: got %0d want 1", err_count); end
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL single_locked: got %b want 1", locked); end
        clean_bits(1);
        vectors++; if (err_pulse !== 1'b0) begin miscompares++; $display("FAIL single_pulse_width: got %b want 0", err_pulse); end
        vectors++; if (err_count !== 16'd1) begin miscompares++; $display("FAIL single_count_hold: got %0d want 1", err_count); end
    endtask

    task automatic test_loss();
        relock();
        repeat (3) flip_bit();
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL loss_early: got %b want 1 after 3 errors", locked); end
        vectors++; if (err_count !== 16'd3) begin miscompares++; $display("FAIL loss_count3: got %0d want 3", err_count); end
        flip_bit();
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL loss_unlock: got %b want 0 after 4 errors", locked); end
        vectors++; if (err_count !== 16'd4) begin miscompares++; $display("FAIL loss_count4: got %0d want 4", err_count); end
        vectors++; if (err_pulse !== 1'b1) begin miscompares++; $display("FAIL loss_pulse: got %b want 1", err_pulse); end
        clean_bits(23);
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reacq_early: got %b want 0 after 23 bits", locked); end
        vectors++; if (err_count !== 16'd4) begin miscompares++; $display("FAIL search_count: got %0d want 4", err_count); end
        clean_bits(1);
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL reacq_24: got %b want 1", locked); end
    endtask

    task automatic test_zero();
        int seen = 0;
        pulse_reset();
        for (int i = 0; i < 200; i++) begin
            send(1'b0, 1'b1, 1'b0);
            if (locked !== 1'b0) seen++;
        end
        vectors++; if (seen != 0) begin miscompares++; $display("FAIL zero_lock: locked seen %0d cycles want 0", seen); end
    endtask

    task automatic test_enable_toggle();
        logic b, rb, nb;
        pulse_reset();
        for (int k = 1; k <= 24; k++) begin
            gen_next(b);
            send(b, 1'b1, 1'b0);
            if (k == 23) begin
                vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL toggle_early: got %b want 0", locked); end
            end
            if (k == 24) begin
                vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL toggle_lock: got %b want 1", locked); end
            end
            rb = 1'($urandom_range(0, 1));
            send(rb, 1'b0, 1'b0);
        end
        // A disabled edge carrying a wrong bit must be ignored.
        nb = g[7] ^ g[5] ^ g[3];
        send(~nb, 1'b0, 1'b0);
        vectors++; if (err_pulse !== 1'b0) begin miscompares++; $display("FAIL disabled_pulse: got %b want 0", err_pulse); end
        vectors++; if (err_count !== 16'd0) begin miscompares++; $display("FAIL disabled_count: got %0d want 0", err_count); end
        clean_bits(5);
        vectors++; if (err_count !== 16'd0) begin miscompares++; $display("FAIL disabled_align: got %0d want 0", err_count); end
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL disabled_locked: got %b want 1", locked); end
    endtask

    task automatic test_saturate();
        logic b;
        relock();
        repeat (20) begin
            flip_bit();
            clean_bits(2);
        end
        vectors++; if (err_count !== 16'd20) begin miscompares++; $display("FAIL count20: got %0d want 20", err_count); end
        vectors++; if (err_count4 !== 4'd15) begin miscompares++; $display("FAIL sat15: got %0d want 15", err_count4); end
        vectors++; if (locked4 !== 1'b1) begin miscompares++; $display("FAIL sat_locked: got %b want 1", locked4); end
        gen_next(b);
        send(~b, 1'b1, 1'b1);
        vectors++; if (err_count !== 16'd0) begin miscompares++; $display("FAIL clear_count: got %0d want 0", err_count); end
        vectors++; if (err_count4 !== 4'd0) begin miscompares++; $display("FAIL clear_count4: got %0d want 0", err_count4); end
        vectors++; if (err_pulse4 !== 1'b1) begin miscompares++; $display("FAIL clear_pulse: got %b want 1", err_pulse4); end
        clean_bits(1);
        vectors++; if (err_count !== 16'd0) begin miscompares++; $display("FAIL clear_hold: got %0d want 0", err_count); end
    endtask

    task automatic test_async_reset();
        relock();
        flip_bit();
        vectors++; if (err_count !== 16'd1) begin miscompares++; $display("FAIL pre_reset_count: got %0d want 1", err_count); end
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL async_locked: got %b want 0", locked); end
        vectors++; if (err_count !== 16'd0) begin miscompares++; $display("FAIL async_count: got %0d want 0", err_count); end
        vectors++; if (err_pulse !== 1'b0) begin miscompares++; $display("FAIL async_pulse: got %b want 0", err_pulse); end
        @(negedge clk);
        reset = 1'b1;
        clean_bits(23);
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL post_reset_early: got %b want 0", locked); end
        clean_bits(1);
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL post_reset_lock: got %b want 1", locked); end
    endtask

    initial begin
        g = 8'hFF;
        test_reset();
        test_lock();
        test_single_err();
        test_loss();
        test_zero();
        test_enable_toggle();
        test_saturate();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
